// File: rtl/axil_param_regbank_if.sv
// rtl/axil_param_regbank_if.sv - AXI4-Lite bus bundle between a register-bank slave and its master
interface axil_param_regbank_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axil_param_regbank.sv
// rtl/axil_param_regbank.sv - AXI4-Lite register bank: CTRL/START word, STATUS snapshot, RW parameter words
module axil_param_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_NUM_REGS         = 8
) (
    input  logic                                         S_AXI_ACLK,
    input  logic                                         S_AXI_ARESETN,
    axil_param_regbank_if.slave                          s_axi,
    output logic                                         start_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                status_in,
    output logic [(C_NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0] regs_out
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int NB  = DW / 8;
    localparam int IW  = AW - 2;
    localparam int IW1 = IW + 1;
    localparam int NP  = C_NUM_REGS - 2;
    localparam logic [IW:0]   NUM_REGS_W  = IW1'(C_NUM_REGS);
    localparam logic [DW-1:0] CTRL_MASK   = ~DW'(1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic          rst_done;
    logic          aw_held, w_held;
    logic [IW-1:0] aw_idx_q;
    logic [DW-1:0] w_data_q;
    logic [NB-1:0] w_strb_q;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_strb;
    logic          wr_in_range, rd_in_range;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] prm [NP];
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;
    logic          unused_addr_lsbs;

    // Byte lanes within a word carry no meaning here; only the word index decodes.
    assign unused_addr_lsbs = &{1'b0, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [NB-1:0] strb);
        logic [DW-1:0] res;
        res = old_w;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return res;
    endfunction

    assign aw_hs   = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs    = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign ar_hs   = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    // A latched half of the write takes precedence over the live bus.
    assign wr_idx      = aw_held ? aw_idx_q : s_axi.S_AXI_AWADDR[AW-1:2];
    assign wr_data     = w_held ? w_data_q : s_axi.S_AXI_WDATA;
    assign wr_strb     = w_held ? w_strb_q : s_axi.S_AXI_WSTRB;
    assign wr_in_range = {1'b0, wr_idx} < NUM_REGS_W;
    assign rd_idx      = s_axi.S_AXI_ARADDR[AW-1:2];
    assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_W;

    // Write FSM
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) w_state <= W_IDLE;
        else                w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (commit) w_state_nxt = W_RESP;
            W_RESP:  if (s_axi.S_AXI_BREADY) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi.S_AXI_AWREADY = 1'b0;
        s_axi.S_AXI_WREADY  = 1'b0;
        s_axi.S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi.S_AXI_AWREADY = rst_done && !aw_held;
                s_axi.S_AXI_WREADY  = rst_done && !w_held;
            end
            W_RESP:  s_axi.S_AXI_BVALID = 1'b1;
            default: ;
        endcase
    end

    assign s_axi.S_AXI_BRESP = bresp_q;

    // Read FSM
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) r_state <= R_IDLE;
        else                r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (s_axi.S_AXI_RREADY) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi.S_AXI_ARREADY = 1'b0;
        s_axi.S_AXI_RVALID  = 1'b0;
        case (r_state)
            R_IDLE:  s_axi.S_AXI_ARREADY = rst_done;
            R_DATA:  s_axi.S_AXI_RVALID  = 1'b1;
            default: ;
        endcase
    end

    assign s_axi.S_AXI_RDATA = rdata_q;
    assign s_axi.S_AXI_RRESP = rresp_q;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (rd_idx == IW'(0)) begin
                rd_word = ctrl_q;
            end else if (rd_idx == IW'(1)) begin
                rd_word = status_in;
            end else begin
                for (int j = 0; j < NP; j++) begin
                    if (rd_idx == IW'(j + 2)) rd_word = prm[j];
                end
            end
        end
    end

    // Write latches, register storage and the START strobe
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rst_done    <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx_q    <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bresp_q     <= RESP_OKAY;
            start_pulse <= 1'b0;
            ctrl_q      <= '0;
            for (int j = 0; j < NP; j++) prm[j] <= '0;
        end else begin
            rst_done    <= 1'b1;
            start_pulse <= 1'b0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                if (wr_in_range) begin
                    // START is write-1-to-pulse; it never lands in storage.
                    if (wr_idx == IW'(0)) begin
                        ctrl_q      <= merge_bytes(ctrl_q, wr_data, wr_strb) & CTRL_MASK;
                        start_pulse <= wr_strb[0] && wr_data[0];
                    end
                    for (int j = 0; j < NP; j++) begin
                        if (wr_idx == IW'(j + 2)) prm[j] <= merge_bytes(prm[j], wr_data, wr_strb);
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= s_axi.S_AXI_AWADDR[AW-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.S_AXI_WDATA;
                    w_strb_q <= s_axi.S_AXI_WSTRB;
                end
            end
        end
    end

    // Read capture; nonblocking storage update means a same-edge write is not yet visible.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    for (genvar g = 0; g < NP; g++) begin : g_regs_out
        assign regs_out[g*DW +: DW] = prm[g];
    end
endmodule

// File: tb/tb_axil_param_regbank.sv
// tb/tb_axil_param_regbank.sv - scoreboard bench for axil_param_regbank
module tb_axil_param_regbank;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 start_pulse;
    logic [DW-1:0]        status_in;
    logic [(NR-2)*DW-1:0] regs_out;

    axil_param_regbank_if #(.DW(DW), .AW(AW)) bus ();

    axil_param_regbank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_NUM_REGS(NR)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(resetn),
        .s_axi(bus),
        .start_pulse(start_pulse),
        .status_in(status_in),
        .regs_out(regs_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (start_pulse === 1'b1) pulse_cnt++;
            if (bus.S_AXI_BVALID === 1'b1 && bus.S_AXI_BREADY === 1'b1) begin
                if (bq.size() == 0) check("unexpected_b", 1, 0);
                else check("bresp", bus.S_AXI_BRESP, bq.pop_front());
            end
            if (bus.S_AXI_RVALID === 1'b1 && bus.S_AXI_RREADY === 1'b1) begin
                if (rq.size() == 0) check("unexpected_r", 1, 0);
                else begin
                    e = rq.pop_front();
                    check("rdata", bus.S_AXI_RDATA, e[33:2]);
                    check("rresp", bus.S_AXI_RRESP, e[1:0]);
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            check("drain_timeout", 0, 1);
            bq.delete();
            rq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er);
        bit aw_ok = 0;
        bit w_ok = 0;
        bq.push_back(er);
        bus.S_AXI_AWADDR = a;
        bus.S_AXI_WDATA = d;
        bus.S_AXI_WSTRB = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        for (int n = 0; n < 20 && !(aw_ok && w_ok); n++) begin
            @(negedge clk);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_ok = 1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_ok = 1;
            @(posedge clk); #1;
            if (aw_ok) bus.S_AXI_AWVALID = 1'b0;
            if (w_ok) bus.S_AXI_WVALID = 1'b0;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID = 1'b0;
        if (!(aw_ok && w_ok)) check("write_accept_timeout", 0, 1);
        wait_drain();
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er);
        bit ok = 0;
        rq.push_back({ed, er});
        bus.S_AXI_ARADDR = a;
        bus.S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) ok = 1;
            @(posedge clk); #1;
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!ok) check("ar_timeout", 0, 1);
        else begin
            @(negedge clk);
            check("rvalid_latency", bus.S_AXI_RVALID, 1);
        end
        wait_drain();
    endtask

    initial begin
        int p0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        status_in = 32'hCAFE0001;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        check("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        check("rst_resp", {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 4'h0);
        check("rst_rdata", bus.S_AXI_RDATA, 0);
        check("rst_start", start_pulse, 0);
        check("rst_regs_out", regs_out == '0, 1);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("release_ready_low", bus.S_AXI_AWREADY, 0);
        @(negedge clk);
        check("release_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        @(posedge clk); #1;

        axi_read(6'h08, 32'h0, 2'b00);

        axi_write(6'h08, 32'hDEADBEEF, 4'hF, 2'b00);
        axi_write(6'h08, 32'h0000AA00, 4'h2, 2'b00);
        axi_read(6'h08, 32'hDEADAAEF, 2'b00);
        check("regs_out_w2", regs_out[31:0], 32'hDEADAAEF);
        axi_read(6'h0B, 32'hDEADAAEF, 2'b00);

        // W three cycles ahead of AW, response stalled four cycles
        bus.S_AXI_BREADY = 1'b0;
        bq.push_back(2'b00);
        bus.S_AXI_WDATA = 32'h13579BDF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        check("w_early_ready", bus.S_AXI_WREADY, 1);
        @(posedge clk); #1;
        bus.S_AXI_WVALID = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("w_latched", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}, 3'b010);
            @(posedge clk); #1;
        end
        bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        check("aw_late_ready", bus.S_AXI_AWREADY, 1);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("b_hold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 5'b10000);
            @(posedge clk); #1;
        end
        bus.S_AXI_BREADY = 1'b1;
        wait_drain();
        @(negedge clk);
        check("b_dropped", bus.S_AXI_BVALID, 0);
        @(posedge clk); #1;
        axi_read(6'h0C, 32'h13579BDF, 2'b00);

        // START strobe
        p0 = pulse_cnt;
        axi_write(6'h00, 32'h00000005, 4'hF, 2'b00);
        check("start_once", pulse_cnt - p0, 1);
        axi_read(6'h00, 32'h00000004, 2'b00);
        p0 = pulse_cnt;
        axi_write(6'h00, 32'h00000003, 4'hF, 2'b00);
        axi_write(6'h00, 32'h00000003, 4'hF, 2'b00);
        check("start_b2b", pulse_cnt - p0, 2);
        p0 = pulse_cnt;
        axi_write(6'h00, 32'h00000001, 4'h2, 2'b00);
        check("start_unstrobed", pulse_cnt - p0, 0);
        axi_read(6'h00, 32'h00000002, 2'b00);

        // STATUS, null strobe, last word
        axi_read(6'h04, 32'hCAFE0001, 2'b00);
        axi_write(6'h04, 32'hFFFFFFFF, 4'hF, 2'b00);
        axi_write(6'h10, 32'hFFFFFFFF, 4'h0, 2'b00);
        axi_read(6'h10, 32'h0, 2'b00);
        axi_write(6'h1C, 32'hA5A5A5A5, 4'hF, 2'b00);
        axi_read(6'h1C, 32'hA5A5A5A5, 2'b00);
        check("regs_out_w7", regs_out[5*32 +: 32], 32'hA5A5A5A5);

        // Out of range
        p0 = pulse_cnt;
        axi_write(6'h20, 32'h12345678, 4'hF, 2'b10);
        axi_read(6'h20, 32'h0, 2'b10);
        axi_read(6'h3C, 32'h0, 2'b10);
        check("oor_no_start", pulse_cnt - p0, 0);
        axi_read(6'h08, 32'hDEADAAEF, 2'b00);
        check("oor_regs_out", regs_out, {32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'h13579BDF, 32'hDEADAAEF});

        // Read and write commit to the same word on one edge
        bq.push_back(2'b00);
        rq.push_back({32'h0, 2'b00});
        bus.S_AXI_AWADDR = 6'h14; bus.S_AXI_WDATA = 32'h00000011; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 6'h14;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        check("conc_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        wait_drain();
        axi_read(6'h14, 32'h00000011, 2'b00);

        // Reset while a write response is stalled
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_AWADDR = 6'h10; bus.S_AXI_WDATA = 32'h00000077; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", bus.S_AXI_BVALID, 1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_bvalid", bus.S_AXI_BVALID, 0);
        check("post_rst_regs_out", regs_out == '0, 1);
        bus.S_AXI_BREADY = 1'b1;
        for (int i = 0; i < NR; i++) begin
            axi_read(6'(i * 4), (i == 1) ? 32'hCAFE0001 : 32'h0, 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
